// File: rtl/xadc_channel_scheduler.sv
// Round-robin XADC DRP reader: one read per eoc, results banked per channel.
// Optional XADC_SCHED_AVG_EN: 4-sample averaging per channel before the bank is updated.
module xadc_channel_scheduler #(
  parameter int unsigned N_CH    = 13,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        dclk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        eoc,
  input  logic        drdy,
  input  logic [15:0] do_in,
  output logic        den,
  output logic [6:0]  daddr,
  output logic        result_valid,
  output logic [3:0]  result_ch,
  output logic [11:0] result_data,
  output logic        sweep_done,
  output logic        timeout_err,
  input  logic        err_clr,
  input  logic [3:0]  rd_ch,
  output logic [11:0] rd_data
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_EOC, WAIT_RDY, STORE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    ch;
  logic [11:0]   bank [N_CH];

  logic          last_ch;
  logic [6:0]    ch_addr;
  logic [11:0]   sample;
  logic          timeout_hit;
  logic          unused_bits;

  assign last_ch     = (ch == 4'(N_CH - 1));
  assign ch_addr     = (ch == 4'd0) ? 7'h03 : 7'h0F + 7'(ch);
  assign sample      = do_in[15:4];
  assign timeout_hit = !drdy && (cnt == CW'(TIMEOUT - 1));
  assign unused_bits = ^do_in[3:0];

`ifdef XADC_SCHED_AVG_EN
  logic [13:0] acc  [N_CH];
  logic [1:0]  scnt [N_CH];
  logic [13:0] acc_sum;

  assign acc_sum = acc[ch] + 14'(sample);
`endif

  // Sequencer, result/bank update and registered bank read port
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      ch           <= '0;
      den          <= 1'b0;
      daddr        <= '0;
      result_valid <= 1'b0;
      result_ch    <= '0;
      result_data  <= '0;
      sweep_done   <= 1'b0;
      timeout_err  <= 1'b0;
      rd_data      <= '0;
      for (int i = 0; i < N_CH; i++) begin
        bank[i] <= '0;
`ifdef XADC_SCHED_AVG_EN
        acc[i]  <= '0;
        scnt[i] <= '0;
`endif
      end
    end else begin
      den          <= 1'b0;
      result_valid <= 1'b0;
      sweep_done   <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;
      rd_data <= (32'(rd_ch) < N_CH) ? bank[rd_ch] : 12'h000;

      case (state)
        IDLE: begin
          if (run) state <= WAIT_EOC;
        end
        WAIT_EOC: begin
          if (eoc) begin
            den   <= 1'b1;
            daddr <= ch_addr;
            cnt   <= '0;
            state <= WAIT_RDY;
          end else if (!run) begin
            state <= IDLE;
          end
        end
        WAIT_RDY: begin
          cnt <= cnt + CW'(1);
          if (drdy || timeout_hit) begin
            ch         <= last_ch ? 4'd0 : ch + 4'd1;
            sweep_done <= last_ch;
            state      <= STORE;
          end
          // A timeout leaves the bank alone; the set beats a same-cycle err_clr
          if (timeout_hit) begin
            timeout_err <= 1'b1;
          end else if (drdy) begin
`ifdef XADC_SCHED_AVG_EN
            if (scnt[ch] == 2'd3) begin
              bank[ch]     <= acc_sum[13:2];
              result_valid <= 1'b1;
              result_ch    <= ch;
              result_data  <= acc_sum[13:2];
              acc[ch]      <= '0;
              scnt[ch]     <= '0;
            end else begin
              acc[ch]  <= acc_sum;
              scnt[ch] <= scnt[ch] + 2'd1;
            end
`else
            bank[ch]     <= sample;
            result_valid <= 1'b1;
            result_ch    <= ch;
            result_data  <= sample;
`endif
          end
        end
        STORE: begin
          state <= run ? WAIT_EOC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
